// File: rtl/test_input_sequencer_pkg.sv
// Shared definitions for the test input sequencer and the display driver.
// UI phase codes are rendered directly by the seven-segment driver.
package test_input_sequencer_pkg;

  localparam logic [1:0] UI_SELECT = 2'b00;
  localparam logic [1:0] UI_IN_A   = 2'b01;
  localparam logic [1:0] UI_IN_B   = 2'b10;
  localparam logic [1:0] UI_RUN    = 2'b11;

  localparam int NUM_BTNS = 2;
  localparam int BTN_CONFIRM = 0;
  localparam int BTN_BACK    = 1;
  localparam int SW_W        = 8;

  typedef enum logic [1:0] {
    ST_SELECT = UI_SELECT,
    ST_IN_A   = UI_IN_A,
    ST_IN_B   = UI_IN_B,
    ST_RUN    = UI_RUN
  } ui_state_e;

  typedef struct packed {
    logic back;
    logic confirm;
  } btn_press_t;

  // Register load controls produced by the FSM output decode.
  typedef struct packed {
    logic ld_mode;
    logic clr_ops;
    logic ld_a;
    logic ld_b;
    logic clr_b;
    logic go_run;
  } seq_ctl_t;

endpackage

// File: rtl/test_input_sequencer_btn_debounce.sv
// Button debouncer: 2-FF synchronizer, stability counter, one-cycle press pulse
// on each accepted 0->1 transition.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_CNT_W  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [1:0]          sync_q;
  logic                level_q;
  logic [DB_CNT_W-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synchronized level has disagreed with
  // the accepted level; any agreement (a bounce back) restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      press_o <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        press_o <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/test_input_sequencer.sv
// UI sequencer: debounced confirm/back buttons walk select -> A -> B -> run.
// Optional macro TEST_INPUT_SEQUENCER_SINGLE_OPERAND_EN: mode_o[3] tests skip B.
module test_input_sequencer
  import test_input_sequencer_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_CNT_W  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_confirm_i,
  input  logic            btn_back_i,
  input  logic [SW_W-1:0] sw_i,
  input  logic            done_i,
  output logic [3:0]      mode_o,
  output logic [1:0]      state_o,
  output logic [SW_W-1:0] operand_a_o,
  output logic [SW_W-1:0] operand_b_o,
  output logic            start_o
);

  logic [NUM_BTNS-1:0] raw_btn;
  logic [NUM_BTNS-1:0] press;
  btn_press_t          p;

  assign raw_btn[BTN_CONFIRM] = btn_confirm_i;
  assign raw_btn[BTN_BACK]    = btn_back_i;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_CNT_W  (DB_CNT_W)
  ) u_db [NUM_BTNS-1:0] (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (raw_btn),
    .press_o (press)
  );

  assign p.confirm = press[BTN_CONFIRM];
  assign p.back    = press[BTN_BACK];

  logic [1:0][SW_W-1:0] sw_sync_q;
  logic [SW_W-1:0]      sw_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sw_sync_q <= '0;
    else      sw_sync_q <= {sw_sync_q[0], sw_i};
  end
  assign sw_s = sw_sync_q[1];

  logic skip_b;
`ifdef TEST_INPUT_SEQUENCER_SINGLE_OPERAND_EN
  assign skip_b = mode_o[3];
`else
  assign skip_b = 1'b0;
`endif

  ui_state_e state_q, state_d;
  seq_ctl_t  ctl;
  logic      done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_SELECT;
    else      state_q <= state_d;
  end

  // Confirm is tested first everywhere, so a simultaneous back is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SELECT: if (p.confirm) state_d = ST_IN_A;
      ST_IN_A: begin
        if (p.confirm)   state_d = skip_b ? ST_RUN : ST_IN_B;
        else if (p.back) state_d = ST_SELECT;
      end
      ST_IN_B: begin
        if (p.confirm)   state_d = ST_RUN;
        else if (p.back) state_d = ST_IN_A;
      end
      ST_RUN: if (p.confirm && done_q) state_d = ST_SELECT;
      default: state_d = ST_SELECT;
    endcase
  end

  always_comb begin
    ctl = '0;
    unique case (state_q)
      ST_SELECT: begin
        ctl.ld_mode = p.confirm;
        ctl.clr_ops = p.confirm;
      end
      ST_IN_A: begin
        ctl.ld_a   = p.confirm;
        ctl.clr_b  = p.confirm && skip_b;
        ctl.go_run = p.confirm && skip_b;
      end
      ST_IN_B: begin
        ctl.ld_b   = p.confirm;
        ctl.go_run = p.confirm;
      end
      default: ctl = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_o      <= '0;
      operand_a_o <= '0;
      operand_b_o <= '0;
      start_o     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      start_o <= ctl.go_run;
      if (ctl.ld_mode) mode_o <= sw_s[3:0];
      if (ctl.clr_ops) begin
        operand_a_o <= '0;
        operand_b_o <= '0;
      end
      if (ctl.ld_a)  operand_a_o <= sw_s;
      if (ctl.ld_b)  operand_b_o <= sw_s;
      if (ctl.clr_b) operand_b_o <= '0;
      // Sticky done: cleared on RUN entry so a stale done cannot release RUN.
      if (ctl.go_run)                       done_q <= 1'b0;
      else if (state_q == ST_RUN && done_i) done_q <= 1'b1;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_test_input_sequencer.sv
// Directed bench with a history-window reference model of the sequencer.
module tb_test_input_sequencer;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_confirm_i = 1'b0;
  logic       btn_back_i = 1'b0;
  logic [7:0] sw_i = 8'h00;
  logic       done_i = 1'b0;
  logic [3:0] mode_o;
  logic [1:0] state_o;
  logic [7:0] operand_a_o, operand_b_o;
  logic       start_o;

  test_input_sequencer #(.DB_CYCLES(DB), .DB_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_confirm_i(btn_confirm_i), .btn_back_i(btn_back_i),
    .sw_i(sw_i), .done_i(done_i), .mode_o(mode_o), .state_o(state_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .start_o(start_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;
  int chg_tick = -1;

  // Reference model: raw input histories (index k = sampled k edges ago).
  logic       hc[6], hb[6];
  logic [7:0] hs[3];
  logic       acc_c, acc_b, pc, pb;
  int         m_state;
  logic [3:0] m_mode;
  logic [7:0] m_a, m_b;
  logic       m_start, m_done;

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin hc[k] = 1'b0; hb[k] = 1'b0; end
    for (int k = 0; k < 3; k++) hs[k] = 8'h00;
    acc_c = 1'b0; acc_b = 1'b0; pc = 1'b0; pb = 1'b0;
    m_state = 0; m_mode = 4'h0; m_a = 8'h00; m_b = 8'h00;
    m_start = 1'b0; m_done = 1'b0;
  endtask

  // A level is accepted once it has been seen (after 2 sync stages) on DB
  // consecutive edges; pulses produced at one edge are acted on at the next.
  function automatic logic window_flip(input logic h[6], input logic acc);
    logic all_diff = 1'b1;
    for (int k = 2; k < 2 + DB; k++) if (h[k] == acc) all_diff = 1'b0;
    return all_diff;
  endfunction

  task automatic model_step();
    logic c, b, old_done;
    logic [7:0] sws;
    if (!rst) begin model_reset(); return; end
    for (int k = 5; k > 0; k--) begin hc[k] = hc[k-1]; hb[k] = hb[k-1]; end
    for (int k = 2; k > 0; k--) hs[k] = hs[k-1];
    hc[0] = btn_confirm_i; hb[0] = btn_back_i; hs[0] = sw_i;
    c = pc; b = pb; sws = hs[2];
    m_start = 1'b0;
    old_done = m_done;
    case (m_state)
      0: if (c) begin m_mode = sws[3:0]; m_a = 8'h00; m_b = 8'h00; m_state = 1; end
      1: if (c) begin
           m_a = sws;
`ifdef TEST_INPUT_SEQUENCER_SINGLE_OPERAND_EN
           if (m_mode[3]) begin m_b = 8'h00; m_start = 1'b1; m_done = 1'b0; m_state = 3; end
           else m_state = 2;
`else
           m_state = 2;
`endif
         end else if (b) m_state = 0;
      2: if (c) begin m_b = sws; m_start = 1'b1; m_done = 1'b0; m_state = 3; end
         else if (b) m_state = 1;
      default: begin
        if (c && old_done) m_state = 0;
        else if (done_i) m_done = 1'b1;
      end
    endcase
    pc = 1'b0; pb = 1'b0;
    if (window_flip(hc, acc_c)) begin acc_c = ~acc_c; pc = acc_c; end
    if (window_flip(hb, acc_b)) begin acc_b = ~acc_b; pb = acc_b; end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {9'b0, state_o, mode_o, operand_a_o, operand_b_o, start_o};
  endfunction

  function automatic logic [31:0] model_vec();
    return {9'b0, m_state[1:0], m_mode, m_a, m_b, m_start};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("cycle", dut_vec(), model_vec());
    if (start_o) start_cnt++;
  endtask

  // Clean press: hold 8 cycles, release 8; records when state_o first moves.
  task automatic press(input logic c, input logic b);
    logic [1:0] prev = state_o;
    chg_tick = -1;
    btn_confirm_i = c; btn_back_i = b;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (chg_tick < 0 && state_o != prev) chg_tick = i;
    end
    btn_confirm_i = 1'b0; btn_back_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    check("reset_outs", dut_vec(), 32'h0);
    rst = 1'b1;
    tick();

    // Bouncing confirm, then a steady hold: one press only.
    sw_i = 8'h05;
    for (int i = 0; i < 20; i++) begin
      btn_confirm_i = ((i / 2) % 2) == 0;
      tick();
      check("bounce_hold_sel", {30'b0, state_o}, 32'd0);
    end
    btn_confirm_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_confirm_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("bounce_state", {30'b0, state_o}, 32'd1);
    check("bounce_mode", {28'b0, mode_o}, 32'h5);

    // Full flow to RUN.
    sw_i = 8'h3C; press(1'b1, 1'b0);
    check("press_latency", chg_tick, 2 + DB + 1);
    check("flow_in_b", {30'b0, state_o}, 32'd2);
    start_cnt = 0;
    sw_i = 8'hA1; press(1'b1, 1'b0);
    check("flow_run", {9'b0, state_o, mode_o, operand_a_o, operand_b_o, 1'b0},
          {9'b0, 2'b11, 4'h5, 8'h3C, 8'hA1, 1'b0});
    check("start_once", start_cnt, 1);

    // RUN exit needs a done before confirm; back is ignored.
    press(1'b0, 1'b1);
    check("run_back_ign", {30'b0, state_o}, 32'd3);
    press(1'b1, 1'b0);
    check("run_no_done", {30'b0, state_o}, 32'd3);
    done_i = 1'b1; tick(); done_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    press(1'b1, 1'b0);
    check("run_exit", {30'b0, state_o}, 32'd0);

    // Back path.
    sw_i = 8'h07; press(1'b1, 1'b0);
    check("sel_clr_a", {24'b0, operand_a_o}, 32'h0);
    sw_i = 8'h11; press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("back_to_a", {22'b0, state_o, operand_a_o}, {22'b0, 2'b01, 8'h11});
    press(1'b0, 1'b1);
    check("back_to_sel", {26'b0, state_o, mode_o}, {26'b0, 2'b00, 4'h7});
    press(1'b0, 1'b1);
    check("back_in_sel", {26'b0, state_o, mode_o}, {26'b0, 2'b00, 4'h7});

    // Simultaneous confirm+back in IN_A: confirm wins.
    sw_i = 8'h02; press(1'b1, 1'b0);
    sw_i = 8'h44; press(1'b1, 1'b1);
    check("both_in_a", {22'b0, state_o, operand_a_o}, {22'b0, 2'b10, 8'h44});
    sw_i = 8'h55; press(1'b1, 1'b0);
    check("run_again", {30'b0, state_o}, 32'd3);

    // Asynchronous reset mid-RUN, away from any clock edge.
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst", dut_vec(), 32'h0);
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b1;
    tick();

    // Mode with bit 3 set.
    sw_i = 8'h09; press(1'b1, 1'b0);
    start_cnt = 0;
    sw_i = 8'h66; press(1'b1, 1'b0);
`ifdef TEST_INPUT_SEQUENCER_SINGLE_OPERAND_EN
    check("single_op", {13'b0, state_o, operand_a_o, operand_b_o, start_cnt[0]},
          {13'b0, 2'b11, 8'h66, 8'h00, 1'b1});
`else
    check("single_op", {13'b0, state_o, operand_a_o, operand_b_o, start_cnt[0]},
          {13'b0, 2'b10, 8'h66, 8'h00, 1'b0});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
